// File: rtl/bits_req_arbiter.sv
// Round-robin arbiter sharing one bit-extractor between two requesters.
// One request outstanding at a time, with response routing and a response timeout.
module bits_req_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int LENW    = 4,
  parameter int DATAW   = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [LENW-1:0]  len0,
  input  logic [LENW-1:0]  len1,
  output logic             ack0,
  output logic             ack1,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [LENW-1:0]  rsp0_len,
  output logic [LENW-1:0]  rsp1_len,
  output logic [DATAW-1:0] rsp0_data,
  output logic [DATAW-1:0] rsp1_data,
  output logic             ext_reqin,
  output logic [LENW-1:0]  ext_reqlen,
  input  logic             ext_pushout,
  input  logic [LENW-1:0]  ext_lenout,
  input  logic [DATAW-1:0] ext_dataout,
  output logic             busy,
  output logic             len_mismatch,
  output logic             timeout_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]       r_state;
  logic             r_last_grant;
  logic             r_grant;
  logic [LENW-1:0]  r_len;
  logic [7:0]       r_cnt;
  logic             r_ack0, r_ack1;
  logic             r_rsp0_valid, r_rsp1_valid;
  logic [LENW-1:0]  r_rsp0_len, r_rsp1_len;
  logic [DATAW-1:0] r_rsp0_data, r_rsp1_data;
  logic             r_ext_reqin;
  logic [LENW-1:0]  r_ext_reqlen;
  logic             r_busy;
  logic             r_len_mismatch;
  logic             r_timeout_err;

  logic             w_sample;
  logic             w_win;
  logic [LENW-1:0]  w_win_len;
  logic             w_timeout_hit;

  // Requests are not re-sampled in the cycle an ack is visible, so a held req is not double-granted.
  always_comb begin
    w_sample      = (r_state == S_IDLE) && !(r_ack0 || r_ack1) && (req0 || req1);
    w_timeout_hit = (r_cnt == 8'(TIMEOUT - 1));
    if (req0 && req1) begin
      w_win = ~r_last_grant;
    end else begin
      w_win = req1;
    end
    if (w_win) begin
      w_win_len = len1;
    end else begin
      w_win_len = len0;
    end
  end

  // Arbitration, issue, response routing and timeout; every output is a register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_last_grant   <= 1'b1;
      r_grant        <= 1'b0;
      r_len          <= {LENW{1'b0}};
      r_cnt          <= 8'd0;
      r_ack0         <= 1'b0;
      r_ack1         <= 1'b0;
      r_rsp0_valid   <= 1'b0;
      r_rsp1_valid   <= 1'b0;
      r_rsp0_len     <= {LENW{1'b0}};
      r_rsp1_len     <= {LENW{1'b0}};
      r_rsp0_data    <= {DATAW{1'b0}};
      r_rsp1_data    <= {DATAW{1'b0}};
      r_ext_reqin    <= 1'b0;
      r_ext_reqlen   <= {LENW{1'b0}};
      r_busy         <= 1'b0;
      r_len_mismatch <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_ack0         <= 1'b0;
      r_ack1         <= 1'b0;
      r_rsp0_valid   <= 1'b0;
      r_rsp1_valid   <= 1'b0;
      r_ext_reqin    <= 1'b0;
      r_len_mismatch <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_sample) begin
            r_grant      <= w_win;
            r_last_grant <= w_win;
            r_len        <= w_win_len;
            r_ack0       <= ~w_win;
            r_ack1       <= w_win;
            if (w_win_len != {LENW{1'b0}}) begin
              r_ext_reqin  <= 1'b1;
              r_ext_reqlen <= w_win_len;
              r_cnt        <= 8'd0;
              r_busy       <= 1'b1;
              r_state      <= S_WAIT;
            end else if (w_win) begin
              r_rsp1_valid <= 1'b1;
              r_rsp1_len   <= {LENW{1'b0}};
              r_rsp1_data  <= {DATAW{1'b0}};
            end else begin
              r_rsp0_valid <= 1'b1;
              r_rsp0_len   <= {LENW{1'b0}};
              r_rsp0_data  <= {DATAW{1'b0}};
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (ext_pushout || w_timeout_hit) begin
            // A timeout answers the waiting port with an empty response.
            if (r_grant) begin
              r_rsp1_valid <= 1'b1;
              r_rsp1_len   <= ext_pushout ? ext_lenout : {LENW{1'b0}};
              r_rsp1_data  <= ext_pushout ? ext_dataout : {DATAW{1'b0}};
            end else begin
              r_rsp0_valid <= 1'b1;
              r_rsp0_len   <= ext_pushout ? ext_lenout : {LENW{1'b0}};
              r_rsp0_data  <= ext_pushout ? ext_dataout : {DATAW{1'b0}};
            end
            if (ext_pushout) begin
              r_len_mismatch <= (ext_lenout != r_len);
            end else begin
              r_timeout_err <= 1'b1;
            end
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0         = r_ack0;
  assign ack1         = r_ack1;
  assign rsp0_valid   = r_rsp0_valid;
  assign rsp1_valid   = r_rsp1_valid;
  assign rsp0_len     = r_rsp0_len;
  assign rsp1_len     = r_rsp1_len;
  assign rsp0_data    = r_rsp0_data;
  assign rsp1_data    = r_rsp1_data;
  assign ext_reqin    = r_ext_reqin;
  assign ext_reqlen   = r_ext_reqlen;
  assign busy         = r_busy;
  assign len_mismatch = r_len_mismatch;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_bits_req_arbiter.sv
// Bench for bits_req_arbiter: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level model.
module tb_bits_req_arbiter;
  localparam int TIMEOUT = 8;
  localparam int LENW    = 4;
  localparam int DATAW   = 15;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [LENW-1:0] len0 = '0, len1 = '0;
  logic ext_pushout = 1'b0;
  logic [LENW-1:0] ext_lenout = '0;
  logic [DATAW-1:0] ext_dataout = '0;
  logic ack0, ack1, rsp0_valid, rsp1_valid, ext_reqin, busy, len_mismatch, timeout_err;
  logic [LENW-1:0] rsp0_len, rsp1_len, ext_reqlen;
  logic [DATAW-1:0] rsp0_data, rsp1_data;

  bits_req_arbiter #(.TIMEOUT(TIMEOUT), .LENW(LENW), .DATAW(DATAW)) dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .ack0(ack0), .ack1(ack1), .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_len(rsp0_len), .rsp1_len(rsp1_len), .rsp0_data(rsp0_data), .rsp1_data(rsp1_data),
    .ext_reqin(ext_reqin), .ext_reqlen(ext_reqlen), .ext_pushout(ext_pushout),
    .ext_lenout(ext_lenout), .ext_dataout(ext_dataout), .busy(busy),
    .len_mismatch(len_mismatch), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Expected outputs for the current cycle.
  logic e_ack0 = 0, e_ack1 = 0, e_rv0 = 0, e_rv1 = 0, e_reqin = 0, e_busy = 0, e_mism = 0, e_terr = 0;
  logic [LENW-1:0] e_rl0 = '0, e_rl1 = '0, e_reqlen = '0;
  logic [DATAW-1:0] e_rd0 = '0, e_rd1 = '0;
  // Outstanding transaction: who, how long, which cycle it was issued in.
  bit m_out = 0, m_port = 0, m_last = 1;
  logic [LENW-1:0] m_len = '0;
  int m_issue = 0;
  int cyc = 0;
  int n_vec = 0, n_err = 0;
  int ext_cd = -1;
  bit drop0 = 0, drop1 = 0;
  int gq[$];
  int lq[$];

  task automatic give(input bit p, input logic [LENW-1:0] l, input logic [DATAW-1:0] d);
    if (p) begin e_rv1 = 1; e_rl1 = l; e_rd1 = d; end
    else begin e_rv0 = 1; e_rl0 = l; e_rd0 = d; end
  endtask

  // Outputs the DUT must show after the coming edge, from the current inputs.
  task automatic model_step();
    bit ack_vis;
    bit p;
    logic [LENW-1:0] l;
    ack_vis = e_ack0 | e_ack1;
    e_ack0 = 0; e_ack1 = 0; e_rv0 = 0; e_rv1 = 0; e_reqin = 0; e_mism = 0;
    if (!reset) begin
      e_rl0 = '0; e_rl1 = '0; e_rd0 = '0; e_rd1 = '0; e_reqlen = '0; e_terr = 0;
      m_out = 0; m_last = 1;
    end else if (!m_out) begin
      if (!ack_vis && (req0 || req1)) begin
        p = (req0 && req1) ? !m_last : req1;
        m_last = p;
        l = p ? len1 : len0;
        if (p) e_ack1 = 1; else e_ack0 = 1;
        if (l != 0) begin
          e_reqin = 1; e_reqlen = l; m_out = 1; m_port = p; m_len = l; m_issue = cyc + 1;
        end else begin
          give(p, '0, '0);
        end
      end
    end else if (ext_pushout) begin
      give(m_port, ext_lenout, ext_dataout);
      e_mism = (ext_lenout != m_len);
      m_out = 0;
    end else if (cyc + 1 == m_issue + TIMEOUT) begin
      give(m_port, '0, '0);
      e_terr = 1;
      m_out = 0;
    end
    e_busy = m_out;
  endtask

  task automatic tick();
    logic [49:0] got, exp;
    model_step();
    @(posedge clock);
    #1;
    cyc++;
    got = {ack0, ack1, rsp0_valid, rsp1_valid, rsp0_len, rsp1_len, rsp0_data, rsp1_data,
           ext_reqin, ext_reqlen, busy, len_mismatch, timeout_err};
    exp = {e_ack0, e_ack1, e_rv0, e_rv1, e_rl0, e_rl1, e_rd0, e_rd1,
           e_reqin, e_reqlen, e_busy, e_mism, e_terr};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL cycle %0d outputs: got %h, expected %h", cyc, got, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  initial begin
    // Reset
    reset = 0;
    tick(); tick();
    chk("reset_busy", busy, 0);
    chk("reset_terr", timeout_err, 0);
    chk("reset_ack", {ack0, ack1, ext_reqin}, 0);
    reset = 1;
    tick();

    // Single request, extractor answers two cycles after issue
    req0 = 1; len0 = 4'd5;
    tick();
    chk("single_ack0", ack0, 1);
    chk("single_reqin", ext_reqin, 1);
    chk("single_reqlen", ext_reqlen, 5);
    chk("single_busy", busy, 1);
    tick();
    req0 = 0;
    tick();
    ext_pushout = 1; ext_lenout = 4'd5; ext_dataout = 15'h001F;
    tick();
    chk("single_rsp_valid", rsp0_valid, 1);
    chk("single_rsp_len", rsp0_len, 5);
    chk("single_rsp_data", rsp0_data, 15'h001F);
    chk("single_busy_done", busy, 0);
    ext_pushout = 0;
    tick();

    // Zero-length request never touches the extractor
    req1 = 1; len1 = 4'd0;
    tick();
    chk("zero_ack1", ack1, 1);
    chk("zero_rsp1_valid", rsp1_valid, 1);
    chk("zero_rsp1_len", rsp1_len, 0);
    chk("zero_reqin", ext_reqin, 0);
    tick();
    req1 = 0;
    tick();

    // Timeout with a late pushout that must be dropped
    req0 = 1; len0 = 4'd4;
    tick();
    chk("to_reqin", ext_reqin, 1);
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      req0 = 0;
      chk("to_no_rsp_early", rsp0_valid, 0);
    end
    tick();
    chk("to_rsp_valid", rsp0_valid, 1);
    chk("to_rsp_len", rsp0_len, 0);
    chk("to_err", timeout_err, 1);
    tick(); tick();
    ext_pushout = 1; ext_lenout = 4'd4; ext_dataout = 15'h1234;
    tick();
    ext_pushout = 0;
    tick();
    chk("to_late_dropped", rsp0_valid, 0);
    chk("to_err_sticky", timeout_err, 1);

    // Zero-latency extractor with a short answer
    req1 = 1; len1 = 4'd6;
    tick();
    ext_pushout = 1; ext_lenout = 4'd2; ext_dataout = 15'h0003;
    tick();
    chk("mm_rsp1_valid", rsp1_valid, 1);
    chk("mm_rsp1_len", rsp1_len, 2);
    chk("mm_pulse", len_mismatch, 1);
    ext_pushout = 0; req1 = 0;
    tick();
    chk("mm_pulse_once", len_mismatch, 0);

    // Contention with both requests held
    req0 = 1; req1 = 1; len0 = 4'd3; len1 = 4'd7;
    for (int k = 0; k < 16; k++) begin
      ext_pushout = e_reqin; ext_lenout = e_reqlen; ext_dataout = 15'($urandom);
      tick();
      if (ack0) gq.push_back(0);
      if (ack1) gq.push_back(1);
      if (ext_reqin) lq.push_back(int'(ext_reqlen));
    end
    req0 = 0; req1 = 0; ext_pushout = e_reqin; ext_lenout = e_reqlen;
    tick();
    ext_pushout = 0;
    tick();
    chk("cont_count", (gq.size() >= 4 && lq.size() >= 4) ? 1 : 0, 1);
    if (gq.size() >= 4 && lq.size() >= 4) begin
      chk("cont_grants", {gq[0][3:0], gq[1][3:0], gq[2][3:0], gq[3][3:0]}, 32'h0101);
      chk("cont_lens", {lq[0][3:0], lq[1][3:0], lq[2][3:0], lq[3][3:0]}, 32'h3737);
    end

    // Reset in the middle of WAIT
    req0 = 1; len0 = 4'd5;
    tick();
    req0 = 0; reset = 0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    reset = 1; ext_pushout = 1; ext_lenout = 4'd5;
    tick();
    chk("rst_pushout_dropped", rsp0_valid | rsp1_valid, 0);
    ext_pushout = 0; req0 = 1; req1 = 1; len0 = 4'd2; len1 = 4'd2;
    tick();
    chk("rst_port0_first", {ack0, ack1}, 2'b10);
    tick();
    req0 = 0; req1 = 0;
    ext_pushout = 1; ext_lenout = 4'd2;
    tick();
    ext_pushout = 0;
    tick();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 299) != 0);
      if (req0) begin
        if (drop0) begin req0 = 0; drop0 = 0; end
        else if (e_ack0) drop0 = 1;
      end else if ($urandom_range(0, 2) == 0) begin
        req0 = 1; len0 = 4'($urandom_range(0, 15));
      end
      if (req1) begin
        if (drop1) begin req1 = 0; drop1 = 0; end
        else if (e_ack1) drop1 = 1;
      end else if ($urandom_range(0, 2) == 0) begin
        req1 = 1; len1 = 4'($urandom_range(0, 15));
      end
      if (e_reqin) ext_cd = $urandom_range(0, 10);
      ext_pushout = (ext_cd == 0) || ($urandom_range(0, 31) == 0);
      if (ext_cd >= 0) ext_cd--;
      ext_lenout = ($urandom_range(0, 4) == 0) ? 4'($urandom) : m_len;
      ext_dataout = 15'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bits_req_arbiter.md
Name: bits_req_arbiter

Overview:
- Shares one bit-extractor (32-bit word FIFO front end, up to 15 bits per request) between two requesters, e.g. a header parser on port 0 and a payload decoder on port 1.
- Grants requests round-robin, issues one extractor request at a time, and routes the extractor response back to the granted port.
- Enforces a single outstanding request and runs a response timeout.

Parameters:
- TIMEOUT, 64, maximum cycles to wait for ext_pushout after issue (legal 2..255).
- LENW, 4, width of every length field.
- DATAW, 15, width of every data field.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- req0 / req1  in  1  request from port 0 / 1; held high until the matching ack
- len0 / len1  in  LENW  requested bit count (0..15); stable while reqN high
- ack0 / ack1  out  1  one-cycle grant pulse
- rsp0_valid / rsp1_valid  out  1  one-cycle response strobe
- rsp0_len / rsp1_len  out  LENW  returned bit count
- rsp0_data / rsp1_data  out  DATAW  returned bits
- ext_reqin  out  1  one-cycle request to the extractor
- ext_reqlen  out  LENW  length issued to the extractor
- ext_pushout  in  1  extractor response strobe
- ext_lenout  in  LENW  extractor response length
- ext_dataout  in  DATAW  extractor response data
- busy  out  1  high while a request is outstanding (state WAIT)
- len_mismatch  out  1  one-cycle pulse when ext_lenout != issued length
- timeout_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset (reset==0 at posedge):
  - All outputs go to 0 and state goes to IDLE.
  - last_grant=1, so port 0 wins first.
  - Timeout counter and stored grant/length are cleared.
- States: IDLE, WAIT. All outputs are registered.
- Grant rule in IDLE, evaluated at posedge T:
  - Only one reqN high: that port wins.
  - Both high: the port != last_grant wins.
  - The winner is stored as grant, last_grant is updated, and lenN is latched.
- Non-zero length, cycle T+1:
  - ackN=1, ext_reqin=1, ext_reqlen=latched len.
  - State=WAIT, busy=1, timeout counter=0.
- Zero length: no extractor access. In cycle T+1: ackN=1, rspN_valid=1, rspN_len=0, rspN_data=0; state stays IDLE.
- WAIT, ext_pushout=1 at a posedge (including the cycle ext_reqin is high):
  - Next cycle: rsp[grant]_valid=1, rsp_len=ext_lenout, rsp_data=ext_dataout.
  - len_mismatch pulses if ext_lenout != latched len.
  - State returns to IDLE, busy=0.
  - A new grant may be sampled in that same IDLE cycle, so back-to-back throughput is one request per 2 cycles with a zero-latency extractor.
- WAIT, ext_pushout=0:
  - Counter increments each cycle.
  - At the posedge where counter==TIMEOUT-1: next cycle rsp[grant]_valid=1 with len=0, data=0; timeout_err set; state returns to IDLE.
  - A late ext_pushout after that point is dropped.
- ext_pushout while in IDLE (spurious or post-reset): ignored. No rsp, no error.
- Requests are not sampled while in WAIT; reqN simply stays pending.
- Rsp outputs hold their last data when valid=0; only the valid strobes are pulses.
- Requester obligation: deassert reqN in the cycle after ackN is seen. The arbiter does not re-sample reqN in the cycle ackN is high.
- Synchronous reset mid-WAIT aborts the request: no response is produced and the extractor's later pushout is dropped.

Test Plan:
- Single request: req0=1, len0=5 from reset; extractor returns pushout 2 cycles after ext_reqin with len=5, data=0x001F -> ack0 and ext_reqin/ext_reqlen=5 in the same cycle; rsp0_valid one cycle after pushout with len=5, data=0x001F; busy high exactly the WAIT cycles.
- Contention: req0 and req1 both high with len0=3, len1=7, held continuously -> grants alternate 0,1,0,1; ext_reqlen sequence 3,7,3,7; each response reaches only the granted port; no ack while busy.
- Zero length: req1=1, len1=0 -> ack1 and rsp1_valid in the same cycle, rsp1_len=0; ext_reqin never asserted.
- Timeout: TIMEOUT=8, req0 len=4, ext_pushout held 0 -> rsp0_valid with len=0 exactly 8 cycles after ext_reqin; timeout_err=1 and stays 1; a pushout arriving 3 cycles later is ignored.
- Mismatch and zero-latency extractor: ext_pushout asserted in the same cycle as ext_reqin with ext_lenout=2 for a request of 6 -> rsp len=2 next cycle, len_mismatch pulses once.
- Reset mid-WAIT: pull reset low for 1 cycle during WAIT, then deliver pushout -> all outputs 0, no rsp, timeout_err=0; the next req1 and req0 together grant port 0 first.
